// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised synchronous RAM answering each
// load/store with a one-cycle ack after WAIT_CYCLES wait states.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_en,
    output logic [31:0] read_data,
    output logic        ack,
    output logic        busy,
    output logic        addr_err
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("data_mem_responder: WAIT_CYCLES must be in 0..15");
    end

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t             state, state_next;
    logic [3:0]         cnt, cnt_next;
    logic               wr_q;
    logic [31:0]        addr_q, wdata_q;
    logic [3:0]         be_q;
    logic               cur_wr, cur_err, enter_ack;
    logic [31:0]        cur_addr, cur_wdata;
    logic [3:0]         cur_be;
    logic [ADDR_W-1:0]  waddr;
    logic [31:0]        mem [2**ADDR_W];

    // With zero wait states the ack edge is also the sampling edge, so the
    // access is described by the live inputs in IDLE and by the latches after.
    always_comb begin
        if (state == S_IDLE) begin
            cur_wr    = mem_write;
            cur_addr  = addr;
            cur_wdata = write_data;
            cur_be    = byte_en;
        end else begin
            cur_wr    = wr_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
        waddr   = cur_addr[ADDR_W+1:2];
        cur_err = ((cur_addr >> (ADDR_W + 2)) != '0)
                || (cur_be == 4'hF && cur_addr[1:0] != 2'b00)
                || (cur_be == 4'h0);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = S_ACK;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) state_next = S_ACK;
            end
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        enter_ack = (state_next == S_ACK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            read_data <= '0;
            addr_err  <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == S_IDLE && req) begin
                wr_q    <= mem_write;
                addr_q  <= addr;
                wdata_q <= write_data;
                be_q    <= byte_en;
            end
            if (enter_ack) begin
                addr_err  <= cur_err;
                read_data <= (cur_wr || cur_err) ? '0 : mem[waddr];
            end else begin
                addr_err  <= 1'b0;
                read_data <= '0;
            end
        end
    end

    // Gated by reset so an in-flight store is dropped, never committed.
    always_ff @(posedge clk) begin
        if (reset && enter_ack && cur_wr && !cur_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cur_be[i]) mem[waddr][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

    assign ack  = (state == S_ACK);
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance
// checked against a word-array memory model with byte-lane merging.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_req, a_wr, a_ack, a_busy, a_err;
    logic [31:0] a_addr, a_wdata, a_rd;
    logic [3:0]  a_be;
    logic        b_req, b_wr, b_ack, b_busy, b_err;
    logic [31:0] b_addr, b_wdata, b_rd;
    logic [3:0]  b_be;

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .req(a_req), .mem_write(a_wr), .addr(a_addr),
        .write_data(a_wdata), .byte_en(a_be), .read_data(a_rd), .ack(a_ack),
        .busy(a_busy), .addr_err(a_err)
    );

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .req(b_req), .mem_write(b_wr), .addr(b_addr),
        .write_data(b_wdata), .byte_en(b_be), .read_data(b_rd), .ack(b_ack),
        .busy(b_busy), .addr_err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_err(input logic [31:0] ad, input logic [3:0] be);
        return ((ad >> 12) != 0) || (be == 4'hF && ad[1:0] != 2'b00) || (be == 4'h0);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // One access on the 2-wait-state instance; ack expected after the
    // third edge counting the sampling edge as the first.
    task automatic acc_a(input logic wr, input logic [31:0] ad, input logic [31:0] d,
                         input logic [3:0] be, input bit drop, input bit hold,
                         input string tag, output logic [31:0] got);
        logic        e;
        logic [9:0]  w;
        logic [31:0] exp_rd;
        e = is_err(ad, be);
        w = ad[11:2];
        exp_rd = (wr || e) ? 32'h0 : mem_a[w];
        if (wr && !e) mem_a[w] = merge(mem_a[w], d, be);
        got = 32'h0;
        @(negedge clk);
        a_req = 1'b1; a_wr = wr; a_addr = ad; a_wdata = d; a_be = be;
        @(posedge clk); #1;
        for (int k = 0; k <= 2; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            chk({tag, " ack"},  32'(a_ack),  32'(k == 2));
            chk({tag, " busy"}, 32'(a_busy), 32'h1);
            if (k == 2) begin
                chk({tag, " read_data"}, a_rd, exp_rd);
                chk({tag, " addr_err"},  32'(a_err), 32'(e));
                got = a_rd;
            end else begin
                chk({tag, " rd_idle"}, a_rd, 32'h0);
            end
            if (k == 0 && drop) begin
                @(negedge clk);
                a_req = 1'b0; a_wr = ~wr; a_addr = $urandom; a_wdata = $urandom;
                a_be = 4'($urandom_range(0, 15));
            end
            if (k == 2 && !hold) begin
                @(negedge clk);
                a_req = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk({tag, " post ack"},  32'(a_ack),  32'h0);
        chk({tag, " post busy"}, 32'(a_busy), 32'h0);
        chk({tag, " post rd"},   a_rd,        32'h0);
        chk({tag, " post err"},  32'(a_err),  32'h0);
        @(negedge clk);
        a_req = 1'b0;
    endtask

    task automatic acc_b(input logic wr, input logic [31:0] ad, input logic [31:0] d,
                         input logic [3:0] be, input string tag);
        logic        e;
        logic [9:0]  w;
        logic [31:0] exp_rd;
        e = is_err(ad, be);
        w = ad[11:2];
        exp_rd = (wr || e) ? 32'h0 : mem_b[w];
        if (wr && !e) mem_b[w] = merge(mem_b[w], d, be);
        @(negedge clk);
        b_req = 1'b1; b_wr = wr; b_addr = ad; b_wdata = d; b_be = be;
        @(posedge clk); #1;
        chk({tag, " ack"},       32'(b_ack),  32'h1);
        chk({tag, " busy"},      32'(b_busy), 32'h1);
        chk({tag, " read_data"}, b_rd,        exp_rd);
        chk({tag, " addr_err"},  32'(b_err),  32'(e));
        @(negedge clk);
        b_req = 1'b0;
        @(posedge clk); #1;
        chk({tag, " post ack"},  32'(b_ack),  32'h0);
        chk({tag, " post busy"}, 32'(b_busy), 32'h0);
    endtask

    initial begin
        logic [31:0] got, ad;
        logic [3:0]  be;
        a_req = 0; a_wr = 0; a_addr = 0; a_wdata = 0; a_be = 0;
        b_req = 0; b_wr = 0; b_addr = 0; b_wdata = 0; b_be = 0;
        reset = 1'b0;
        #1;
        chk("reset ack",  32'(a_ack),  32'h0);
        chk("reset busy", 32'(a_busy), 32'h0);
        chk("reset rd",   a_rd,        32'h0);
        chk("reset err",  32'(a_err),  32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed: full-word store/load, then byte-lane merge.
        acc_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, "t1 store", got);
        acc_a(1'b0, 32'h10, 32'h0, 4'hF, 0, 0, "t1 load", got);
        chk("t1 data", got, 32'hDEADBEEF);
        acc_a(1'b1, 32'h10, 32'h11223344, 4'hF, 0, 0, "t2 store", got);
        acc_a(1'b1, 32'h11, 32'h5A5A5A5A, 4'b0010, 0, 0, "t2 byte", got);
        acc_a(1'b0, 32'h10, 32'h0, 4'hF, 0, 0, "t2 load", got);
        chk("t2 data", got, 32'h11225A44);

        // Out-of-range store must not alias onto word 0.
        acc_a(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 0, "t3 init", got);
        acc_a(1'b1, 32'h1000, 32'h12345678, 4'hF, 0, 0, "t3 oor", got);
        acc_a(1'b0, 32'h0, 32'h0, 4'hF, 0, 0, "t3 load", got);
        chk("t3 data", got, 32'hCAFEF00D);

        // Dropped req still completes; held req does not restart in ACK.
        acc_a(1'b1, 32'h20, 32'hA5A5_0001, 4'hF, 1, 0, "t4 drop", got);
        acc_a(1'b0, 32'h20, 32'h0, 4'hF, 0, 1, "t4 hold", got);
        chk("t4 data", got, 32'hA5A50001);

        // Reset mid-WAIT of a store: outputs clear immediately, store dropped.
        @(negedge clk);
        a_req = 1'b1; a_wr = 1'b1; a_addr = 32'h20; a_wdata = 32'h0BAD0BAD; a_be = 4'hF;
        @(posedge clk); #1;
        chk("t5 busy before", 32'(a_busy), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("t5 ack",  32'(a_ack),  32'h0);
        chk("t5 busy", 32'(a_busy), 32'h0);
        chk("t5 rd",   a_rd,        32'h0);
        a_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        acc_a(1'b0, 32'h20, 32'h0, 4'hF, 0, 0, "t5 load", got);
        chk("t5 data", got, 32'hA5A50001);

        // Zero wait states: back-to-back loads with req held.
        acc_b(1'b1, 32'hC, 32'h600DF00D, 4'hF, "t6 store");
        acc_b(1'b0, 32'hC, 32'h0, 4'h0, "t6 be0");
        @(negedge clk);
        b_req = 1'b1; b_wr = 1'b0; b_addr = 32'hC; b_be = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("t6 b2b ack",  32'(b_ack),  32'(k % 2 == 0));
            chk("t6 b2b busy", 32'(b_busy), 32'(k % 2 == 0));
            chk("t6 b2b rd",   b_rd, (k % 2 == 0) ? mem_b[3] : 32'h0);
        end
        @(negedge clk);
        b_req = 1'b0;

        // Randomised traffic on words 0..15 of the wait-state instance.
        for (int i = 0; i < 16; i++)
            acc_a(1'b1, 32'(i) << 2, $urandom, 4'hF, 0, 0, "r init", got);
        for (int i = 0; i < 40; i++) begin
            be = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0)
                ad = ($urandom_range(1, 32'hFFFFF) << 12) | $urandom_range(0, 4095);
            else if (be == 4'hF && $urandom_range(0, 3) != 0)
                ad = $urandom_range(0, 15) << 2;
            else
                ad = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            acc_a(1'($urandom_range(0, 1)), ad, $urandom, be,
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "rand", got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
